// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined add/subtract unit.
//   - FLG_* : bit positions of the individual ALU flags inside alu_flags_t
//   - alu_flags_t : packed flag word {N, Z, AC, V, C} (index 4 down to 0)
//   - sat_value() : signed saturation constant for a given width
// Build option: ADDSUB_SAT_EN (uses sat_value() to clamp overflowing results).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int FLG_C  = 0;   // carry out of MSB (sub: 1 = no borrow)
    localparam int FLG_V  = 1;   // signed overflow
    localparam int FLG_AC = 2;   // carry out of bit 3
    localparam int FLG_Z  = 3;   // result is zero
    localparam int FLG_N  = 4;   // result MSB
    localparam int NFLAGS = 5;

    typedef logic [NFLAGS-1:0] alu_flags_t;

    // Signed saturation limit for a 'width'-bit result, returned right-aligned
    // in 64 bits: sign=0 gives the signed maximum (0x7F..F), sign=1 the signed
    // minimum (0x80..0). Callers keep the low 'width' bits (width <= 64).
    function automatic logic [63:0] sat_value(input int width, input logic sign);
        logic [63:0] v;
        v = '0;
        if (sign) begin
            v[width-1] = 1'b1;
        end else begin
            for (int i = 0; i < width - 1; i++) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// full_adder / addsub_slice
// One CHUNK-bit ripple-carry slice of the pipelined adder, built from
// single-bit full_adder cells.
// full_adder ports:
//   a_i, b_i, c_i : operand bits and carry in
//   s_o, co_o     : sum bit and carry out
// addsub_slice parameters:
//   CHUNK   : slice width in bits
//   AUX_BIT : local bit index whose carry-out is reported on aux_o
// addsub_slice ports:
//   a_i, b_i : CHUNK-bit operand chunks (b_i already inverted for subtract)
//   c_i      : carry into the slice LSB
//   sum_o    : CHUNK-bit sum chunk
//   cout_o   : carry out of the slice MSB
//   cmsb_o   : carry into the slice MSB (needed for signed overflow)
//   aux_o    : carry out of local bit AUX_BIT
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module addsub_slice
    import alu_pkg::*;
#(
    parameter int CHUNK   = 8,
    parameter int AUX_BIT = 3
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o,
    output logic             aux_o
);
    // carry[i] is the carry into local bit i; carry[CHUNK] leaves the slice.
    logic [CHUNK:0] carry;

    assign carry[0] = c_i;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
        full_adder u_fa (
            .a_i  (a_i[gi]),
            .b_i  (b_i[gi]),
            .c_i  (carry[gi]),
            .s_o  (sum_o[gi]),
            .co_o (carry[gi+1])
        );
    end

    assign cout_o = carry[CHUNK];
    assign cmsb_o = carry[CHUNK-1];
    assign aux_o  = carry[AUX_BIT+1];

endmodule

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
// Pipelined WIDTH-bit add/subtract unit with ALU flags. The carry chain is cut
// into STAGES slices of CHUNK = WIDTH/STAGES bits; slice k adds chunk k using
// the carry registered by slice k-1. One beat per cycle, latency STAGES cycles,
// valid/ready handshake with a single global stall.
// Parameters:
//   WIDTH  : operand/result width (>= 8, <= 64, multiple of STAGES)
//   STAGES : number of pipeline slices
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake
//   A, B, Cin, Sub      : operands; Sub=0 -> A+B+Cin, Sub=1 -> A-B-Cin
//   out_valid/out_ready : result handshake
//   Sum                 : result
//   Cout                : carry out of MSB (sub: 1 = no borrow)
//   Overflow            : signed overflow
//   AuxCarry            : carry out of bit 3
//   Zero, Negative      : Sum == 0, Sum MSB
// Build option: ADDSUB_SAT_EN -- on signed overflow Sum clamps to the signed
//   max/min chosen by the sign of A; Cout/Overflow/AuxCarry stay raw, Zero and
//   Negative follow the clamped Sum. Undefined: Sum wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             AuxCarry,
    output logic             Zero,
    output logic             Negative
);
    localparam int CHUNK    = WIDTH / STAGES;
    localparam int LAST     = STAGES - 1;
    localparam int AC_STAGE = 3 / CHUNK;   // slice that owns bit 3
    localparam int AC_BIT   = 3 % CHUNK;   // bit 3 as a local index in that slice
    localparam int NP       = (STAGES > 1) ? STAGES - 1 : 1;

    // Global stall: the whole pipe advances whenever the output slot frees up.
    logic adv;

    // Subtract is folded into an add at capture: A + ~B + ~Cin.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Inputs seen by each slice (port values for slice 0, registers otherwise).
    logic             st_vld [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic             st_c   [STAGES];
    logic             st_ac  [STAGES];

    // Slice results and the next-state values built from them.
    logic [CHUNK-1:0] sl_sum  [STAGES];
    logic             sl_cout [STAGES];
    logic             sl_cmsb [STAGES];
    logic             sl_aux  [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             ac_d    [STAGES];

    // Intermediate pipeline registers between slices.
    logic             vld_q [NP];
    logic [WIDTH-1:0] a_q   [NP];
    logic [WIDTH-1:0] b_q   [NP];
    logic [WIDTH-1:0] sum_q [NP];
    logic             c_q   [NP];
    logic             ac_q  [NP];

    // Output registers (the final stage).
    logic             out_vld_q;
    logic [WIDTH-1:0] sum_out_q;
    logic [WIDTH-1:0] sum_out_d;
    alu_flags_t       flags_q;
    alu_flags_t       flags_d;

    logic [WIDTH-1:0] sum_raw;
    logic             v_raw;

    assign adv      = !out_vld_q || out_ready;
    assign in_ready = adv;

    assign b_eff = Sub ? ~B : B;
    assign c_eff = Sub ? ~Cin : Cin;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // Bits of the full-width word owned by this slice.
        localparam logic [WIDTH-1:0] MASK =
            ({WIDTH{1'b1}} >> (WIDTH - CHUNK)) << (gi * CHUNK);

        if (gi == 0) begin : g_first
            assign st_vld[gi] = in_valid;
            assign st_a[gi]   = A;
            assign st_b[gi]   = b_eff;
            assign st_sum[gi] = '0;
            assign st_c[gi]   = c_eff;
            assign st_ac[gi]  = 1'b0;
        end else begin : g_next
            assign st_vld[gi] = vld_q[gi-1];
            assign st_a[gi]   = a_q[gi-1];
            assign st_b[gi]   = b_q[gi-1];
            assign st_sum[gi] = sum_q[gi-1];
            assign st_c[gi]   = c_q[gi-1];
            assign st_ac[gi]  = ac_q[gi-1];
        end

        addsub_slice #(
            .CHUNK   (CHUNK),
            .AUX_BIT (AC_BIT)
        ) u_slice (
            .a_i    (st_a[gi][gi*CHUNK +: CHUNK]),
            .b_i    (st_b[gi][gi*CHUNK +: CHUNK]),
            .c_i    (st_c[gi]),
            .sum_o  (sl_sum[gi]),
            .cout_o (sl_cout[gi]),
            .cmsb_o (sl_cmsb[gi]),
            .aux_o  (sl_aux[gi])
        );

        // Lower chunks ride along from earlier slices; this slice fills its own.
        assign sum_d[gi] = (st_sum[gi] & ~MASK) | (WIDTH'(sl_sum[gi]) << (gi * CHUNK));

        // AuxCarry is produced by the slice owning bit 3, then just forwarded.
        if (gi == AC_STAGE) begin : g_ac_own
            assign ac_d[gi] = sl_aux[gi];
        end else begin : g_ac_fwd
            assign ac_d[gi] = st_ac[gi];
        end
    end

    // Final stage: full-width result is complete here, so flags are formed here.
    assign sum_raw = sum_d[LAST];
    assign v_raw   = sl_cmsb[LAST] ^ sl_cout[LAST];

`ifdef ADDSUB_SAT_EN
    logic [63:0] sat_full;
    // A's sign picks the direction of the overflow (B is already folded in).
    assign sat_full = sat_value(WIDTH, st_a[LAST][WIDTH-1]);
`endif

    always_comb begin
        sum_out_d = sum_raw;
`ifdef ADDSUB_SAT_EN
        if (v_raw) begin
            sum_out_d = sat_full[WIDTH-1:0];
        end
`endif
        flags_d         = '0;
        flags_d[FLG_C]  = sl_cout[LAST];
        flags_d[FLG_V]  = v_raw;
        flags_d[FLG_AC] = ac_d[LAST];
        flags_d[FLG_Z]  = (sum_out_d == '0);
        flags_d[FLG_N]  = sum_out_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NP; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                ac_q[k]  <= 1'b0;
            end
            out_vld_q <= 1'b0;
            sum_out_q <= '0;
            flags_q   <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                vld_q[k] <= st_vld[k];
                a_q[k]   <= st_a[k];
                b_q[k]   <= st_b[k];
                sum_q[k] <= sum_d[k];
                c_q[k]   <= sl_cout[k];
                ac_q[k]  <= ac_d[k];
            end
            out_vld_q <= st_vld[LAST];
            sum_out_q <= sum_out_d;
            flags_q   <= flags_d;
        end
    end

    assign out_valid = out_vld_q;
    assign Sum       = sum_out_q;
    assign Cout      = flags_q[FLG_C];
    assign Overflow  = flags_q[FLG_V];
    assign AuxCarry  = flags_q[FLG_AC];
    assign Zero      = flags_q[FLG_Z];
    assign Negative  = flags_q[FLG_N];

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
// Scoreboard bench for pipelined_addsub (WIDTH=16, STAGES=2): accepted beats
// push the reference result into a queue, a monitor pops and compares every
// delivered result. Directed cases, backpressure, async reset and a random run.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic         ac;
        logic         z;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout, ovf, aux, zero, neg;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_done = 1'b0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .Sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (sum),
        .Cout      (cout),
        .Overflow  (ovf),
        .AuxCarry  (aux),
        .Zero      (zero),
        .Negative  (neg)
    );

    // Reference model: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xc, input logic xs);
        exp_t        e;
        int unsigned ua = xa;
        int unsigned ub = xb;
        int unsigned ci = xc;
        int          sa = int'($signed(xa));
        int          sb = int'($signed(xb));
        int          sr;
        int unsigned ur;
        if (!xs) begin
            ur   = ua + ub + ci;
            sr   = sa + sb + int'(ci);
            e.c  = (ur > 32'd65535);
            e.ac = ((ua % 16) + (ub % 16) + ci) > 15;
        end else begin
            ur   = ua - ub - ci;
            sr   = sa - sb - int'(ci);
            e.c  = (ua >= ub + ci);
            e.ac = ((ua % 16) >= (ub % 16) + ci);
        end
        e.sum = ur[W-1:0];
        e.v   = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
        if (e.v) e.sum = (sa >= 0) ? 16'h7FFF : 16'h8000;
`endif
        e.z = (e.sum == '0);
        e.n = e.sum[W-1];
        return e;
    endfunction

    function automatic exp_t dut_now();
        return {sum, cout, ovf, aux, zero, neg};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard producer: every accepted beat queues its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            $display("in : A=%h B=%h Cin=%b Sub=%b", a, b, cin, sub);
        end
    end

    // Scoreboard consumer: compare whenever a result is handed over.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got Sum=%h with no beat outstanding, required none", sum);
            end else begin
                e = exp_q.pop_front();
                $display("out: Sum=%h C=%b V=%b AC=%b Z=%b N=%b", sum, cout, ovf, aux, zero, neg);
                check("result", 64'(dut_now()), 64'(e));
            end
        end
    end

    // Present one beat and return 1 ns after the edge that accepts it.
    task automatic drive(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, input logic xs);
        int n;
        n = 0;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 100 cycles, required 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e1;
        int   n;

        // ---- reset state ----
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_flags", 64'({cout, ovf, aux, zero, neg}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // ---- directed: 0x7FFF + 1, with latency check ----
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_due", 64'(out_valid), 64'd1);
`ifdef ADDSUB_SAT_EN
        check("t1_sum", 64'(sum), 64'h7FFF);
        check("t1_flags_CVAZN", 64'({cout, ovf, aux, zero, neg}), 64'b01100);
`else
        check("t1_sum", 64'(sum), 64'h8000);
        check("t1_flags_CVAZN", 64'({cout, ovf, aux, zero, neg}), 64'b01101);
`endif

        // ---- directed: wrap-around and subtracts, back to back ----
        @(posedge clk); #1;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(16'h0005, 16'h0005, 1'b0, 1'b1);
        drive(16'h0003, 16'h0005, 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("directed_drained", 64'(exp_q.size()), 64'd0);

        // ---- backpressure ----
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(16'h1234, 16'h1111, 1'b1, 1'b0);
        drive(16'h4000, 16'h0001, 1'b0, 1'b1);
        a = 16'h8000; b = 16'h0001; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        e1 = model(16'h1234, 16'h1111, 1'b1, 1'b0);
        repeat (6) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_hold", 64'(dut_now()), 64'(e1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(16'h8000, 16'h0001, 1'b0, 1'b1);
        drive(16'h00FF, 16'h0F01, 1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // ---- asynchronous reset with two beats in flight ----
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(16'h0101, 16'h0202, 1'b0, 1'b0);
        drive(16'h0303, 16'h0101, 1'b1, 1'b1);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_flags", 64'({cout, ovf, aux, zero, neg}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_reset_idle", 64'(out_valid), 64'd0);
        end

        // ---- random traffic ----
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    while ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
                end
                in_valid  = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("random_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
